// File: rtl/cache_arbiter.sv
// Serialises I-cache line fills and D-cache fills/writebacks onto the single pmem port.
// Define CACHE_ARBITER_RR_EN to alternate I/D grants instead of fixed D-over-I priority.
module cache_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              icache_read_i,
   input  logic [ADDR_W-1:0] icache_address_i,
   output logic [LINE_W-1:0] icache_rdata_o,
   output logic              icache_resp_o,
   input  logic              dcache_read_i,
   input  logic              dcache_write_i,
   input  logic [ADDR_W-1:0] dcache_address_i,
   input  logic [LINE_W-1:0] dcache_wdata_i,
   output logic [LINE_W-1:0] dcache_rdata_o,
   output logic              dcache_resp_o,
   output logic              pmem_read_o,
   output logic              pmem_write_o,
   output logic [ADDR_W-1:0] pmem_address_o,
   output logic [LINE_W-1:0] pmem_wdata_o,
   input  logic [LINE_W-1:0] pmem_rdata_i,
   input  logic              pmem_resp_i
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SERVE_I    = 2'd1,
      SERVE_D_RD = 2'd2,
      SERVE_D_WR = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic              pmem_read_q, pmem_write_q;
   logic              dcache_req;
   logic              prefer_d;

`ifdef CACHE_ARBITER_RR_EN
   // last_grant_q: 0 = I-cache completed last, 1 = D-cache completed last
   logic last_grant_q;
   assign prefer_d = ~last_grant_q;
`else
   assign prefer_d = 1'b1;
`endif

   assign dcache_req = dcache_read_i | dcache_write_i;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (dcache_req && (!icache_read_i || prefer_d)) begin
               addr_d = dcache_address_i;
               // writeback goes ahead of the fill when both are requested
               if (dcache_write_i) begin
                  state_d = SERVE_D_WR;
                  wdata_d = dcache_wdata_i;
               end else begin
                  state_d = SERVE_D_RD;
               end
            end else if (icache_read_i) begin
               state_d = SERVE_I;
               addr_d  = icache_address_i;
            end
         end
         default: begin
            if (pmem_resp_i) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         pmem_read_q  <= 1'b0;
         pmem_write_q <= 1'b0;
`ifdef CACHE_ARBITER_RR_EN
         last_grant_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         pmem_read_q  <= (state_d == SERVE_I) || (state_d == SERVE_D_RD);
         pmem_write_q <= (state_d == SERVE_D_WR);
`ifdef CACHE_ARBITER_RR_EN
         if (pmem_resp_i && (state_q != IDLE)) last_grant_q <= (state_q != SERVE_I);
`endif
      end
   end

   assign pmem_read_o    = pmem_read_q;
   assign pmem_write_o   = pmem_write_q;
   assign pmem_address_o = addr_q;
   assign pmem_wdata_o   = wdata_q;

   assign icache_resp_o  = pmem_resp_i && (state_q == SERVE_I);
   assign dcache_resp_o  = pmem_resp_i && ((state_q == SERVE_D_RD) || (state_q == SERVE_D_WR));
   assign icache_rdata_o = pmem_rdata_i;
   assign dcache_rdata_o = pmem_rdata_i;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_cache_arbiter;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned LINE_W = 256;

   logic              clk;
   logic              rst;
   logic              icache_read_i;
   logic [ADDR_W-1:0] icache_address_i;
   logic [LINE_W-1:0] icache_rdata_o;
   logic              icache_resp_o;
   logic              dcache_read_i;
   logic              dcache_write_i;
   logic [ADDR_W-1:0] dcache_address_i;
   logic [LINE_W-1:0] dcache_wdata_i;
   logic [LINE_W-1:0] dcache_rdata_o;
   logic              dcache_resp_o;
   logic              pmem_read_o;
   logic              pmem_write_o;
   logic [ADDR_W-1:0] pmem_address_o;
   logic [LINE_W-1:0] pmem_wdata_o;
   logic [LINE_W-1:0] pmem_rdata_i;
   logic              pmem_resp_i;

   cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .icache_read_i    (icache_read_i),
      .icache_address_i (icache_address_i),
      .icache_rdata_o   (icache_rdata_o),
      .icache_resp_o    (icache_resp_o),
      .dcache_read_i    (dcache_read_i),
      .dcache_write_i   (dcache_write_i),
      .dcache_address_i (dcache_address_i),
      .dcache_wdata_i   (dcache_wdata_i),
      .dcache_rdata_o   (dcache_rdata_o),
      .dcache_resp_o    (dcache_resp_o),
      .pmem_read_o      (pmem_read_o),
      .pmem_write_o     (pmem_write_o),
      .pmem_address_o   (pmem_address_o),
      .pmem_wdata_o     (pmem_wdata_o),
      .pmem_rdata_i     (pmem_rdata_i),
      .pmem_resp_i      (pmem_resp_i)
   );

   typedef struct {
      logic              is_d;
      logic [LINE_W-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_pmem(input string name, input logic rd, input logic wr, input logic [ADDR_W-1:0] a);
      check({name, "_rd"}, LINE_W'(pmem_read_o), LINE_W'(rd));
      check({name, "_wr"}, LINE_W'(pmem_write_o), LINE_W'(wr));
      check({name, "_addr"}, LINE_W'(pmem_address_o), LINE_W'(a));
   endtask

   // Memory completes the current transaction; the matching resp is expected this cycle
   task automatic finish_txn(input logic is_d, input logic [LINE_W-1:0] data);
      exp_t e;
      e.is_d = is_d;
      e.data = data;
      exp_q.push_back(e);
      pmem_rdata_i = data;
      pmem_resp_i  = 1'b1;
      tick();
      pmem_resp_i  = 1'b0;
      pmem_rdata_i = '0;
   endtask

   always @(negedge clk) begin
      if (icache_resp_o || dcache_resp_o) begin
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_resp: got i=%0b d=%0b expected no response", icache_resp_o, dcache_resp_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("resp_who", LINE_W'({icache_resp_o, dcache_resp_o}), LINE_W'(e.is_d ? 2'b01 : 2'b10));
            check("resp_rdata", e.is_d ? dcache_rdata_o : icache_rdata_o, e.data);
         end
      end
   end

   initial begin
      logic [ADDR_W-1:0] first_a, second_a;
      logic              first_d;
      rst = 1'b1;
      icache_read_i = 1'b0;  icache_address_i = '0;
      dcache_read_i = 1'b0;  dcache_write_i = 1'b0;
      dcache_address_i = '0; dcache_wdata_i = '0;
      pmem_rdata_i = '0;     pmem_resp_i = 1'b0;
      tick(); tick();
      expect_pmem("reset", 1'b0, 1'b0, '0);
      check("reset_wdata", pmem_wdata_o, '0);
      rst = 1'b0;
      tick();

      pmem_resp_i = 1'b1;
      #1;
      check("idle_resp_ignored", LINE_W'({icache_resp_o, dcache_resp_o}), '0);
      tick();
      pmem_resp_i = 1'b0;

      // Lone I-fill, memory answers in the 4th strobe cycle
      icache_read_i = 1'b1; icache_address_i = 32'h0000_0060;
      #1;
      check("no_comb_path", LINE_W'(pmem_read_o), '0);
      tick();
      for (int i = 0; i < 3; i++) begin
         expect_pmem("ifill", 1'b1, 1'b0, 32'h60);
         tick();
      end
      expect_pmem("ifill_last", 1'b1, 1'b0, 32'h60);
      finish_txn(1'b0, {32{8'hA5}});
      icache_read_i = 1'b0;
      expect_pmem("ifill_done", 1'b0, 1'b0, 32'h60);

      // Lone D-writeback
      dcache_write_i = 1'b1; dcache_address_i = 32'h1000; dcache_wdata_i = {8{32'hDEADBEEF}};
      tick();
      expect_pmem("dwb", 1'b0, 1'b1, 32'h1000);
      check("dwb_wdata", pmem_wdata_o, {8{32'hDEADBEEF}});
      dcache_wdata_i = '0;
      tick();
      check("dwb_wdata_held", pmem_wdata_o, {8{32'hDEADBEEF}});
      finish_txn(1'b1, {32{8'h11}});
      dcache_write_i = 1'b0;

      // Simultaneous I read 0x40 and D read 0x2000; last completion was D
`ifdef CACHE_ARBITER_RR_EN
      first_d = 1'b0; first_a = 32'h40;   second_a = 32'h2000;
`else
      first_d = 1'b1; first_a = 32'h2000; second_a = 32'h40;
`endif
      icache_read_i = 1'b1; icache_address_i = 32'h40;
      dcache_read_i = 1'b1; dcache_address_i = 32'h2000;
      tick();
      expect_pmem("sim_first", 1'b1, 1'b0, first_a);
      tick();
      finish_txn(first_d, {16{16'h1234}});
      if (first_d) dcache_read_i = 1'b0;
      else         icache_read_i = 1'b0;
      expect_pmem("sim_gap", 1'b0, 1'b0, first_a);
      tick();
      expect_pmem("sim_second", 1'b1, 1'b0, second_a);
      finish_txn(!first_d, {16{16'h5678}});
      icache_read_i = 1'b0; dcache_read_i = 1'b0;

      // D read + write together: writeback first, then the fill
      dcache_read_i = 1'b1; dcache_write_i = 1'b1;
      dcache_address_i = 32'h3000; dcache_wdata_i = {8{32'hCAFE0001}};
      tick();
      expect_pmem("rw_write", 1'b0, 1'b1, 32'h3000);
      check("rw_wdata", pmem_wdata_o, {8{32'hCAFE0001}});
      finish_txn(1'b1, '0);
      dcache_write_i = 1'b0;
      expect_pmem("rw_gap", 1'b0, 1'b0, 32'h3000);
      tick();
      expect_pmem("rw_read", 1'b1, 1'b0, 32'h3000);
      finish_txn(1'b1, {8{32'h0BADF00D}});
      dcache_read_i = 1'b0;

      // Requester address changes mid-transaction
      icache_read_i = 1'b1; icache_address_i = 32'h80;
      tick();
      expect_pmem("addr_hold0", 1'b1, 1'b0, 32'h80);
      icache_address_i = 32'hC0;
      tick();
      expect_pmem("addr_hold1", 1'b1, 1'b0, 32'h80);
      tick();
      expect_pmem("addr_hold2", 1'b1, 1'b0, 32'h80);
      finish_txn(1'b0, {4{64'h0123_4567_89AB_CDEF}});
      icache_read_i = 1'b0;

      // Reset aborts a D fill; a late memory response must not produce a resp
      dcache_read_i = 1'b1; dcache_address_i = 32'h5000;
      tick();
      expect_pmem("abort_pre", 1'b1, 1'b0, 32'h5000);
      rst = 1'b1;
      tick();
      expect_pmem("abort_post", 1'b0, 1'b0, '0);
      rst = 1'b0; dcache_read_i = 1'b0;
      pmem_resp_i = 1'b1; pmem_rdata_i = {32{8'hEE}};
      #1;
      check("abort_late_resp", LINE_W'({icache_resp_o, dcache_resp_o}), '0);
      tick();
      pmem_resp_i = 1'b0; pmem_rdata_i = '0;
      expect_pmem("abort_idle", 1'b0, 1'b0, '0);

      tick(); tick();
      check("scoreboard_drained", LINE_W'(exp_q.size()), '0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Memory-side responder for both L1 caches: accepts line-fill requests from the I-cache and line-fill/writeback requests from the D-cache, and serialises them onto the single physical-memory (cacheline adaptor) port.
- Generates icache_resp_o / dcache_resp_o, the responses the pipeline's hazard logic stalls on.
- Sits between the I-cache/D-cache miss ports and pmem.
- One transaction in flight at a time. No buffering beyond the granted request's latched address/data.

Parameters:
- ADDR_W, 32, byte address width of all address ports.
- LINE_W, 256, cacheline width in bits for all data ports.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- icache_read_i  in  1  I-cache line-fill request (level, held until icache_resp_o)
- icache_address_i  in  ADDR_W  I-cache line address
- icache_rdata_o  out  LINE_W  fill data to I-cache
- icache_resp_o  out  1  one-cycle completion pulse to I-cache
- dcache_read_i  in  1  D-cache line-fill request (level)
- dcache_write_i  in  1  D-cache writeback request (level)
- dcache_address_i  in  ADDR_W  D-cache line address
- dcache_wdata_i  in  LINE_W  writeback data
- dcache_rdata_o  out  LINE_W  fill data to D-cache
- dcache_resp_o  out  1  one-cycle completion pulse to D-cache
- pmem_read_o  out  1  memory read strobe (level, held until pmem_resp_i)
- pmem_write_o  out  1  memory write strobe (level, held until pmem_resp_i)
- pmem_address_o  out  ADDR_W  memory line address
- pmem_wdata_o  out  LINE_W  memory write data
- pmem_rdata_i  in  LINE_W  memory read data, valid with pmem_resp_i
- pmem_resp_i  in  1  memory completion pulse

Behaviour:
- Reset values: all resp_o = 0; pmem_read_o = 0; pmem_write_o = 0; pmem_address_o = 0; pmem_wdata_o = 0; latched grant registers = 0; FSM = IDLE.
- FSM states: IDLE, SERVE_I, SERVE_D_RD, SERVE_D_WR.
- IDLE:
  - Samples requests.
  - On a request, latches the requester's address (and dcache_wdata_i for writes) and moves to the matching SERVE state at the next edge.
  - No request: stays in IDLE.
- SERVE_*:
  - pmem_read_o or pmem_write_o is driven from state: 1 for the whole state, 0 in IDLE.
  - pmem_address_o and pmem_wdata_o are driven from the latched registers. Requester changes to address or data mid-transaction are ignored.
- Completion: when pmem_resp_i = 1 in SERVE_x:
  - The granted requester's resp_o = 1 combinationally in the same cycle; the other resp_o stays 0.
  - Next state = IDLE.
  - pmem_resp_i seen in IDLE is ignored (no resp_o).
- Data paths: icache_rdata_o and dcache_rdata_o are wired directly to pmem_rdata_i. Requesters qualify them with their own resp.
- Latency:
  - Request seen in IDLE at cycle N -> pmem strobe high at N+1.
  - pmem_resp_i at cycle M -> resp_o at M, IDLE at M+1, next pmem strobe at M+2 at the earliest.
  - Requesters must deassert their request by the cycle after their resp, so IDLE never re-grants a completed request.
- Priority (default): D-cache beats I-cache on simultaneous requests. Data misses stall the whole pipeline; instruction misses only bubble the front end.
- D-cache read and write asserted together: write wins (writeback before fill). The read is served in a later transaction if it is still asserted.
- Request arriving during SERVE: waits, stays pending, and is evaluated in IDLE.
- Reset mid-transaction: FSM -> IDLE and strobes drop at the next edge. No resp_o is issued for the aborted transaction. The memory model must tolerate the abort.
- No combinational path from any *_read_i/*_write_i to pmem outputs.

Optional Feature:
- Macro: CACHE_ARBITER_RR_EN.
- Defined:
  - A 1-bit last_grant register (reset 0 = I-cache) is updated on every completion.
  - On simultaneous I and D requests in IDLE, the requester not in last_grant wins. The D-cache write-over-read rule still applies inside a D grant.
- Not defined: fixed D-over-I priority; no last_grant register is present.

Test Plan:
- Lone I-fill: icache_read_i = 1, address 0x0000_0060; memory resp after 4 cycles with rdata = 0xA5 repeated -> pmem_read_o high from N+1 for exactly 4 cycles with address 0x60; icache_resp_o pulses 1 cycle with icache_rdata_o = 0xA5 pattern; dcache_resp_o stays 0.
- Lone D-writeback: dcache_write_i = 1, address 0x1000, wdata 0xDEADBEEF repeated -> pmem_write_o = 1, pmem_wdata_o = 0xDEADBEEF pattern; dcache_resp_o pulses in the pmem_resp_i cycle.
- Simultaneous I read 0x40 and D read 0x2000, macro off -> D served first (pmem_address_o = 0x2000), then I (0x40) with pmem strobe starting 2 cycles after D's resp. Macro on, after a prior D completion -> I served first.
- D read + write both high, address 0x3000 -> write transaction first; read transaction follows if dcache_read_i is still 1.
- Address change mid-transaction: icache_address_i switches 0x80 -> 0xC0 while in SERVE_I -> pmem_address_o holds 0x80 throughout.
- rst asserted for 1 cycle mid SERVE_D_RD -> all strobes 0 at the next edge; no resp_o pulse; a late pmem_resp_i in IDLE produces no resp_o.
